// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the 8-bit CPU datapath.
// Debounces the front-panel buttons and turns them into a one-clock Tick that
// advances the datapath cycle machine, plus a one-clock CpuClear pulse.
module cpu_run_ctrl #(
    parameter int unsigned PRESCALE  = 2048,
    parameter int unsigned DB_CYCLES = 12000
) (
    input  logic       CLK_12MHz,
    input  logic       Reset_n,
    input  logic       BtnRun_n,
    input  logic       BtnStep_n,
    input  logic       BtnClear_n,
    input  logic       CycleIsFetch,
    input  logic       Halted,
    output logic       Tick,
    output logic       CpuClear,
    output logic [1:0] State,
    output logic       Running
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStep = 2'd2,
        StHalt = 2'd3
    } state_e;

    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DbW  = $clog2(DB_CYCLES + 1);
    localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);
    localparam logic [DbW-1:0]  DbMax  = DbW'(DB_CYCLES - 1);

    // Button index: 0 run, 1 step, 2 clear.
    localparam int unsigned BRun   = 0;
    localparam int unsigned BStep  = 1;
    localparam int unsigned BClear = 2;

    logic [2:0]     btn_raw;
    logic [2:0]     sync1_q, sync2_q;
    logic [2:0]     db_q, db_d;       // debounced level, 1 = released
    logic [DbW-1:0] db_cnt_q [3];
    logic [DbW-1:0] db_cnt_d [3];
    logic [2:0]     press;

    state_e          state_q, state_d;
    logic [PreW-1:0] pre_q, pre_d;
    logic [2:0]      tcnt_q, tcnt_d;
    logic            tick_q, tick_d;
    logic            clear_q, clear_d;
    logic            boundary;

    assign btn_raw = {BtnClear_n, BtnStep_n, BtnRun_n};

    // Two-flop synchronisers; reset to the released (high) level.
    always_ff @(posedge CLK_12MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level after DB_CYCLES consecutive differing samples.
    always_comb begin
        db_d  = db_q;
        press = 3'b000;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DbMax) begin
                    db_d[i]  = sync2_q[i];
                    press[i] = ~sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge CLK_12MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            db_q <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign boundary = (pre_q == PreMax);

    // Next-state, prescaler, step counter and registered pulse outputs.
    always_comb begin
        state_d = state_q;
        pre_d   = boundary ? '0 : pre_q + PreW'(1);
        tcnt_d  = tcnt_q;
        tick_d  = 1'b0;
        clear_d = 1'b0;
        if (press[BClear]) begin
            clear_d = 1'b1;
            state_d = StIdle;
            pre_d   = '0;
            tcnt_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (press[BRun]) begin
                        state_d = StRun;
                    end else if (press[BStep]) begin
                        state_d = StStep;
                        tcnt_d  = '0;
                    end
                end
                StRun: begin
                    if (press[BRun]) begin
                        state_d = StIdle;
                    end else if (boundary) begin
                        if (Halted) begin
                            state_d = StHalt;
                        end else begin
                            tick_d = 1'b1;
                        end
                    end
                end
                StStep: begin
                    if (boundary) begin
                        if (Halted) begin
                            state_d = StHalt;
                        end else if (CycleIsFetch && (tcnt_q != 3'd0)) begin
                            // Back at FETCH after at least one advance: instruction done.
                            state_d = StIdle;
                        end else begin
                            tick_d = 1'b1;
                            tcnt_d = (tcnt_q == 3'd7) ? tcnt_q : tcnt_q + 3'd1;
                        end
                    end
                end
                StHalt: begin
                    state_d = StHalt;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge CLK_12MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            pre_q   <= '0;
            tcnt_q  <= '0;
            tick_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            tcnt_q  <= tcnt_d;
            tick_q  <= tick_d;
            clear_q <= clear_d;
        end
    end

    assign Tick     = tick_q;
    assign CpuClear = clear_q;
    assign State    = state_q;
    assign Running  = (state_q == StRun);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl with PRESCALE=4, DB_CYCLES=3.
// Stimulus pushes expected state-change/clear records (with the number of
// Ticks expected since the previous record); the monitor pops on each one.
module tb_cpu_run_ctrl;

    localparam int Pre = 4;

    typedef struct {
        logic [1:0] state;
        logic       clear;
        int         ticks;
    } exp_t;

    logic       clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       btn_run = 1'b1;
    logic       btn_step = 1'b1;
    logic       btn_clear = 1'b1;
    logic       fetch;
    logic       halted = 1'b0;
    logic       tick, cpu_clear, running;
    logic [1:0] state;

    exp_t q[$];
    int   cyc = 0;         // posedges since reset release
    int   pref = 0;        // edge at which the prescaler was last zeroed
    int   tick_total = 0;
    int   step_base = 0;
    bit   done = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    cpu_run_ctrl #(
        .PRESCALE (4),
        .DB_CYCLES(3)
    ) dut (
        .CLK_12MHz   (clk),
        .Reset_n     (Reset_n),
        .BtnRun_n    (btn_run),
        .BtnStep_n   (btn_step),
        .BtnClear_n  (btn_clear),
        .CycleIsFetch(fetch),
        .Halted      (halted),
        .Tick        (tick),
        .CpuClear    (cpu_clear),
        .State       (state),
        .Running     (running)
    );

    always #5 clk = ~clk;

    // Edge counter measured from reset release.
    always @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Datapath model: FETCH before the first Tick of a step, away for three, back after the fourth.
    always_comb begin
        fetch = !(((tick_total - step_base) >= 1) && ((tick_total - step_base) < 4));
    end

    function automatic int count_ticks(input int s, input int f, input int r);
        int c = 0;
        for (int t = s + 1; t < f; t++) begin
            if (((t - r) % Pre) == 0) c++;
        end
        return c;
    endfunction

    task automatic push_exp(input logic [1:0] s, input logic c, input int t);
        exp_t e;
        e.state = s;
        e.clear = c;
        e.ticks = t;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 run, 1 step, 2 clear, 3 run+clear together
    task automatic press(input int which, input int len);
        if (which == 0 || which == 3) btn_run = 1'b0;
        if (which == 1) btn_step = 1'b0;
        if (which == 2 || which == 3) btn_clear = 1'b0;
        repeat (len) @(negedge clk);
        btn_run = 1'b1;
        btn_step = 1'b1;
        btn_clear = 1'b1;
    endtask

    // Stimulus
    initial begin
        int k, s, f, h, c, t1, g;
        repeat (2) @(posedge clk);
        @(negedge clk);
        Reset_n = 1'b1;
        pref = 0;
        idle(50);

        // Short glitch: no event expected.
        press(0, 2);
        idle(10);

        // Run, then second Run press back to idle.
        push_exp(2'd1, 1'b0, 0);
        k = cyc; s = k + 5;
        press(0, 10);
        idle(12);
        k = cyc; f = k + 5;
        push_exp(2'd0, 1'b0, count_ticks(s, f, pref));
        press(0, 10);
        idle(20);

        // Single instruction step from FETCH: four Ticks, then idle.
        step_base = tick_total;
        push_exp(2'd2, 1'b0, 0);
        push_exp(2'd0, 1'b0, 4);
        press(1, 10);
        idle(25);

        // Halt seen at the boundary after it rises mid-slot.
        push_exp(2'd1, 1'b0, 0);
        k = cyc; s = k + 5;
        press(0, 10);
        for (int i = 0; i < 8 && ((cyc - pref) % Pre) != 1; i++) @(negedge clk);
        idle(4);
        h = cyc;
        halted = 1'b1;
        push_exp(2'd3, 1'b0, count_ticks(s, h + 3, pref));
        idle(8);
        press(0, 10);
        idle(10);
        press(1, 10);
        idle(10);
        push_exp(2'd0, 1'b1, 0);
        k = cyc; c = k + 5;
        press(2, 10);
        pref = c;
        halted = 1'b0;
        idle(10);

        // Run and Clear debounced together: Clear wins.
        push_exp(2'd0, 1'b1, 0);
        k = cyc; c = k + 5;
        press(3, 10);
        pref = c;
        idle(20);

        // Run after clear: Tick phase follows the cleared prescaler.
        push_exp(2'd1, 1'b0, 0);
        k = cyc; s = k + 5;
        press(0, 10);
        idle(7);
        k = cyc; f = k + 5;
        push_exp(2'd0, 1'b0, count_ticks(s, f, pref));
        press(0, 10);
        idle(10);

        // Reset mid-step, between the first and second Tick.
        step_base = tick_total;
        push_exp(2'd2, 1'b0, 0);
        k = cyc; s = k + 5;
        press(1, 4);
        t1 = s + 1;
        while (((t1 - pref) % Pre) != 0) t1++;
        g = 0;
        while (cyc < t1 + 2 && g < 20) begin
            @(negedge clk);
            g++;
        end
        push_exp(2'd0, 1'b0, 1);
        #2 Reset_n = 1'b0;
        repeat (2) @(negedge clk);
        Reset_n = 1'b1;
        pref = 0;
        idle(3);

        // Prescaler restarted at release; finish with Clear from RUN.
        push_exp(2'd1, 1'b0, 0);
        k = cyc; s = k + 5;
        press(0, 10);
        idle(6);
        k = cyc; c = k + 5;
        push_exp(2'd0, 1'b1, count_ticks(s, c, pref));
        press(2, 10);
        pref = c;
        idle(10);
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        int   ticks_acc = 0;
        int   nclk = 0;
        logic prev_tick = 1'b0;
        logic [1:0] prev_state = 2'd0;
        forever begin
            @(negedge clk or negedge Reset_n);
            #1;
            nclk++;
            if (!Reset_n) begin
                vectors++;
                if (state !== 2'd0 || tick !== 1'b0 || cpu_clear !== 1'b0 || running !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_values: got State=%0d Tick=%b CpuClear=%b Running=%b, want 0 0 0 0",
                             state, tick, cpu_clear, running);
                end
            end
            if (tick === 1'b1) begin
                ticks_acc++;
                tick_total++;
                vectors++;
                if (((cyc - pref) % Pre) != 0 || prev_tick === 1'b1) begin
                    miscompares++;
                    $display("FAIL tick_phase: got Tick at slot offset %0d (prev Tick=%b), want offset 0, prev 0",
                             (cyc - pref) % Pre, prev_tick);
                end
            end
            prev_tick = tick;
            if (cpu_clear !== 1'b0 || state !== prev_state) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event: got State=%0d CpuClear=%b ticks=%0d, want no event",
                             state, cpu_clear, ticks_acc);
                end else begin
                    e = q.pop_front();
                    if (state !== e.state || cpu_clear !== e.clear || ticks_acc != e.ticks ||
                        running !== (e.state == 2'd1)) begin
                        miscompares++;
                        $display("FAIL event: got State=%0d CpuClear=%b ticks=%0d Running=%b, want State=%0d CpuClear=%b ticks=%0d",
                                 state, cpu_clear, ticks_acc, running, e.state, e.clear, e.ticks);
                    end
                end
                ticks_acc = 0;
            end
            prev_state = state;
            if (done || nclk > 5000) begin
                vectors++;
                if (!done || q.size() != 0 || ticks_acc != 0) begin
                    miscompares++;
                    $display("FAIL drain: got done=%b pending=%0d stray_ticks=%0d, want 1 0 0",
                             done, q.size(), ticks_acc);
                end
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $finish;
            end
        end
    end

endmodule
